hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage 16-bit MIPS datapath. Keeps a shadow tag pipeline (EX/MEM/WB destination tags) for the instructions in flight. From these tags it drives load-use stalls, taken-branch squashes, and the ALU operand forwarding selects. It sits beside the ID stage: it reads decoded register fields and drives the PC/IF-ID enables and the EX operand muxes.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/fwd_sel.sv | 26 ++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding encodings, shadow stage-tag layout
// and the register-write match helper used by the hazard controller.
package pipe_pkg;

  localparam int unsigned REG_AW_DEF = 3;
  // Tag register fields are held at this width; REG_AW must not exceed it.
  localparam int unsigned TAG_AW     = 8;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic              wr_en;
    logic              is_load;
    logic [TAG_AW-1:0] rd;
  } stage_tag_t;

  typedef struct packed {
    logic [TAG_AW-1:0] rs;
    logic [TAG_AW-1:0] rt;
    logic              rs_used;
    logic              rt_used;
  } ex_src_t;

  localparam stage_tag_t TAG_NOP = '0;
  localparam ex_src_t    SRC_NOP = '0;

  // r0 is hard-wired zero, so it never matches as a produced value.
  function automatic logic tag_writes(input stage_tag_t t, input logic [TAG_AW-1:0] r);
    return t.valid & t.wr_en & (t.rd == r) & (r != '0);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// EX operand forwarding select for one source operand: youngest producer
// (MEM) wins over WB, and a load still in MEM has no data to forward yet.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [TAG_AW-1:0] src_i,
  input  logic              used_i,
  input  stage_tag_t        mem_i,
  input  stage_tag_t        wb_i,
  output logic [1:0]        sel_c_o
);

  // A load in WB has its data available, so WB forwarding ignores is_load.
  logic wb_is_load_unused;
  assign wb_is_load_unused = wb_i.is_load;

  always_comb begin
    sel_c_o = FWD_REG;
    if (used_i && tag_writes(mem_i, src_i) && !mem_i.is_load) begin
      sel_c_o = FWD_MEM;
    end else if (used_i && tag_writes(wb_i, src_i)) begin
      sel_c_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: shadow EX/MEM/WB tag pipe,
// load-use stall, taken-branch squash, operand forwarding and event counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush_id,
  output logic              bubble_ex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_tag_t ex_q, ex_d;
  stage_tag_t mem_q, wb_q;
  ex_src_t    ex_src_q, ex_src_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [TAG_AW-1:0] id_rs_w, id_rt_w, id_rd_w;
  logic ex_taken_c, load_use_c, stall_c, flush_c, bubble_c, issue_c;

  assign id_rs_w = TAG_AW'(id_rs);
  assign id_rt_w = TAG_AW'(id_rt);
  assign id_rd_w = TAG_AW'(id_rd);

  // Hazard detection against the instruction currently in EX.
  always_comb begin
    ex_taken_c = ex_branch_taken & ex_q.valid;
    load_use_c = id_valid & ex_q.is_load &
                 ((id_rs_used & tag_writes(ex_q, id_rs_w)) |
                  (id_rt_used & tag_writes(ex_q, id_rt_w)));
    // A squashed consumer need not wait, so the branch flush overrides the stall.
    flush_c  = ex_taken_c;
    stall_c  = load_use_c & ~ex_taken_c;
    bubble_c = ex_taken_c | load_use_c;
    issue_c  = id_valid & ~stall_c & ~ex_taken_c;
  end

  // Next EX tag: the ID instruction when it issues, otherwise a bubble.
  always_comb begin
    ex_d     = TAG_NOP;
    ex_src_d = SRC_NOP;
    if (issue_c) begin
      ex_d.valid       = 1'b1;
      ex_d.wr_en       = id_wr_en;
      ex_d.is_load     = id_is_load;
      ex_d.rd          = id_rd_w;
      ex_src_d.rs      = id_rs_w;
      ex_src_d.rt      = id_rt_w;
      ex_src_d.rs_used = id_rs_used;
      ex_src_d.rt_used = id_rt_used;
    end
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_c && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= TAG_NOP;
      ex_src_q    <= SRC_NOP;
      mem_q       <= TAG_NOP;
      wb_q        <= TAG_NOP;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      ex_src_q    <= ex_src_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  fwd_sel u_fwd_a (
    .src_i   (ex_src_q.rs),
    .used_i  (ex_src_q.rs_used),
    .mem_i   (mem_q),
    .wb_i    (wb_q),
    .sel_c_o (fwd_a)
  );

  fwd_sel u_fwd_b (
    .src_i   (ex_src_q.rt),
    .used_i  (ex_src_q.rt_used),
    .mem_i   (mem_q),
    .wb_i    (wb_q),
    .sel_c_o (fwd_b)
  );

  assign stall     = stall_c;
  assign flush_id  = flush_c;
  assign bubble_ex = bubble_c;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
